vreg_access_ctrl: RTL

VREG_ACCESS_CTRL -- requirements
Module: vreg_access_ctrl

---
 rtl/vreg_access_ctrl_pkg.sv | 25 ++
 rtl/vreg_access_ctrl_if.sv | 50 +++++
 rtl/vreg_access_ctrl_rr_arb2.sv | 48 ++++
 rtl/vreg_access_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/vreg_access_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// vreg_pkg: shared sizing, requester IDs and arbiter pointer type
// Rev 1.0
//------------------------------------------------------------------------------
package vreg_pkg;

  localparam int NUM_VREGS = 8;
  localparam int VREG_AW   = 3;
  localparam int VREG_DW   = 256;

  localparam int NUM_REQ   = 2;
  localparam int REQ_VALU  = 0;
  localparam int REQ_VLSU  = 1;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    PRIO_VALU = 1'b0,
    PRIO_VLSU = 1'b1
  } rr_ptr_e;

endpackage
`default_nettype wire

// File: rtl/vreg_access_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// vreg_access_ctrl_if: requester issue/writeback bus and register-file port
// Rev 1.0
//------------------------------------------------------------------------------
interface vreg_access_ctrl_if #(
  parameter int NUM_VREGS = vreg_pkg::NUM_VREGS,
  parameter int VREG_AW   = vreg_pkg::VREG_AW,
  parameter int VREG_DW   = vreg_pkg::VREG_DW
);
  import vreg_pkg::*;

  // Per-requester vectors, indexed by REQ_VALU / REQ_VLSU.
  req_vec_t                         rd_req;
  logic [NUM_REQ-1:0][VREG_AW-1:0]  rd_srcA;
  logic [NUM_REQ-1:0][VREG_AW-1:0]  rd_srcB;
  req_vec_t                         rd_wr;
  logic [NUM_REQ-1:0][VREG_AW-1:0]  rd_dst;
  req_vec_t                         rd_gnt;
  req_vec_t                         rd_valid;

  req_vec_t                         wb_req;
  logic [NUM_REQ-1:0][VREG_AW-1:0]  wb_addr;
  logic [NUM_REQ-1:0][VREG_DW-1:0]  wb_data;
  req_vec_t                         wb_gnt;

  logic [VREG_AW-1:0]               VreadA;
  logic [VREG_AW-1:0]               VreadB;
  logic                             VwrEn;
  logic [VREG_AW-1:0]               VwrAddr;
  logic [VREG_DW-1:0]               Vwrdata;
  logic [NUM_VREGS-1:0]             busy_vec;
  logic                             wb_err;

  modport slave (
    input  rd_req, rd_srcA, rd_srcB, rd_wr, rd_dst,
    input  wb_req, wb_addr, wb_data,
    output rd_gnt, rd_valid, wb_gnt,
    output VreadA, VreadB, VwrEn, VwrAddr, Vwrdata, busy_vec, wb_err
  );

  modport master (
    output rd_req, rd_srcA, rd_srcB, rd_wr, rd_dst,
    output wb_req, wb_addr, wb_data,
    input  rd_gnt, rd_valid, wb_gnt,
    input  VreadA, VreadB, VwrEn, VwrAddr, Vwrdata, busy_vec, wb_err
  );

endinterface
`default_nettype wire

// File: rtl/vreg_access_ctrl_rr_arb2.sv
`default_nettype none
//------------------------------------------------------------------------------
// rr_arb2: 2-way round-robin arbiter; pointer flips only when both requesters contend
// Rev 1.0
//------------------------------------------------------------------------------
module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] req_i,
  output logic      [1:0] gnt_o
);
  import vreg_pkg::*;

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PRIO_VALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grants are held low for the whole reset interval, not just at the edge.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (rst_n) begin
      case (req_i)
        2'b01: gnt_o = 2'b01;
        2'b10: gnt_o = 2'b10;
        2'b11: begin
          if (ptr_q == PRIO_VALU) begin
            gnt_o = 2'b01;
            ptr_d = PRIO_VLSU;
          end else begin
            gnt_o = 2'b10;
            ptr_d = PRIO_VALU;
          end
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vreg_access_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// vreg_access_ctrl: issue/writeback arbitration and busy scoreboard for the VRF
// Rev 1.0
//------------------------------------------------------------------------------
module vreg_access_ctrl #(
  parameter int NUM_VREGS = vreg_pkg::NUM_VREGS,
  parameter int VREG_AW   = vreg_pkg::VREG_AW,
  parameter int VREG_DW   = vreg_pkg::VREG_DW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  vreg_access_ctrl_if.slave  bus
);
  import vreg_pkg::*;

  logic [NUM_VREGS-1:0] busy_q, busy_d;
  logic                 err_q, err_d;
  req_vec_t             rd_valid_q;
  logic [VREG_AW-1:0]   vra_q, vrb_q;

  req_vec_t             elig;
  req_vec_t             rd_gnt;
  req_vec_t             wb_gnt;
  logic                 rd_win;
  logic                 wb_win;
  logic [VREG_AW-1:0]   vra, vrb;
  logic [VREG_AW-1:0]   wr_addr;
  logic [VREG_DW-1:0]   wr_data;

  // Hazard check sees only the registered scoreboard; a writeback clearing a
  // bit this cycle frees its dependants on the following cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.rd_req[i]
              & ~busy_q[bus.rd_srcA[i]]
              & ~busy_q[bus.rd_srcB[i]]
              & (~bus.rd_wr[i] | ~busy_q[bus.rd_dst[i]]);
    end
  end

  rr_arb2 u_issue_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (elig),
    .gnt_o (rd_gnt)
  );

  rr_arb2 u_wb_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.wb_req),
    .gnt_o (wb_gnt)
  );

  assign rd_win  = rd_gnt[REQ_VLSU];
  assign wb_win  = wb_gnt[REQ_VLSU];
  assign wr_addr = bus.wb_addr[wb_win];
  assign wr_data = bus.wb_data[wb_win];

  always_comb begin
    vra = vra_q;
    vrb = vrb_q;
    if (|rd_gnt) begin
      vra = bus.rd_srcA[rd_win];
      vrb = bus.rd_srcB[rd_win];
    end
  end

  // Clear first, then set, so a forced same-bit set/clear leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (|wb_gnt) begin
      if (!busy_q[wr_addr]) begin
        err_d = 1'b1;
      end
      busy_d[wr_addr] = 1'b0;
    end
    if ((|rd_gnt) && bus.rd_wr[rd_win]) begin
      busy_d[bus.rd_dst[rd_win]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= '0;
      vra_q      <= '0;
      vrb_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_valid_q <= rd_gnt;
      vra_q      <= vra;
      vrb_q      <= vrb;
    end
  end

  assign bus.rd_gnt   = rd_gnt;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wb_gnt   = wb_gnt;
  assign bus.VreadA   = vra;
  assign bus.VreadB   = vrb;
  assign bus.VwrEn    = |wb_gnt;
  assign bus.VwrAddr  = wr_addr;
  assign bus.Vwrdata  = wr_data;
  assign bus.busy_vec = busy_q;
  assign bus.wb_err   = err_q;

endmodule
`default_nettype wire
